hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Stall/flush controller for the ID stage of the 5-stage MIPS pipeline.
- Keeps a per-register scoreboard of in-flight writes issued from ID.
- Raises hazard_detected toward the ID stage's control-zeroing mux; freezes PC and IF/ID on a RAW hazard; flushes IF/ID on a taken branch.
- Supports a runtime forwarding mode, in which only load-use hazards stall.

Parameters:
- WB_LATENCY, 3: stages from ID issue to WB (EXE, MEM, WB). The no-forwarding counter load value is WB_LATENCY-1.
- CNT_W, 2: width of each per-register countdown counter. Must hold WB_LATENCY-1.
- STALL_CNT_W, 16: width of the saturating stall statistics counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-low.
- fwd_en, input, 1: 1 = forwarding unit present, so only loads are tracked.
- id_valid, input, 1: ID holds a real instruction (0 = bubble).
- id_src1, input, 5: first source register of the ID instruction.
- id_src2, input, 5: second source register (already muxed for ST/BNE).
- id_use_src2, input, 1: src2 is read. Equals !is_immediate | ST_or_BNE.
- id_dest, input, 5: destination register of the ID instruction.
- id_WB_en, input, 1: the ID instruction writes the register file (pre-hazard-protection).
- id_MEM_R_en, input, 1: the ID instruction is a load.
- id_Br_taken, input, 1: the ID instruction is a taken branch/jump (pre-hazard-protection).
- hazard_detected, output, 1: RAW hazard on the current ID instruction. Combinational.
- freeze, output, 1: hold PC and the IF/ID register. Equals hazard_detected.
- flush, output, 1: clear the IF/ID register next edge. Equals id_Br_taken & id_valid & !hazard_detected.
- stall_count, output, STALL_CNT_W: number of cycles with hazard_detected=1. Saturating, registered.

Behaviour:
- State: pend[1..31], each a CNT_W-bit counter. Register 0 has no counter and never hazards.
- Reset:
  - On a rising clk edge with rst=0, all pend counters and stall_count are cleared to 0.
  - Consequently hazard_detected, freeze and flush are 0 whenever id_valid=0, or all counters are 0 after reset.
  - Reset mid-operation discards all in-flight tracking, with no partial state retained.
- Hazard (combinational, same cycle):
  - Condition: hazard_detected = id_valid & ((id_src1!=0 & pend[id_src1]!=0) | (id_use_src2 & id_src2!=0 & pend[id_src2]!=0)).
  - The register file writes through in WB, so a counter value of 0 means the result is readable.
- Issue:
  - An instruction issues in a cycle when id_valid & !hazard_detected.
  - A stalled instruction does not issue. ID inserts a bubble (the control-zeroing mux) and re-presents the same instruction next cycle.
- Counter update, every rising edge with rst=1:
  - Every nonzero pend decrements by 1.
  - If the instruction issues, id_WB_en=1 and id_dest!=0, then pend[id_dest] is loaded instead:
    - fwd_en=0: load WB_LATENCY-1 (default 2).
    - fwd_en=1 and id_MEM_R_en=1: load 1.
    - fwd_en=1 and id_MEM_R_en=0: no load; the counter just decrements.
  - A load on a register overrides its decrement in the same cycle.
- Resulting stall lengths, default parameters:
  - fwd_en=0, dependent instruction immediately after the writer: 2 stall cycles.
  - fwd_en=0, one independent instruction in between: 1 stall cycle.
  - fwd_en=0, two or more in between: 0 stall cycles.
  - fwd_en=1, load followed immediately by a dependent use: 1 stall cycle.
  - fwd_en=1, ALU producer: 0 stall cycles.
- Self-dependence: an instruction reading and writing the same register checks the old counter value before its own load.
- Branch:
  - flush is asserted only for a taken branch that is not stalled.
  - A stalled branch asserts flush on the cycle it finally issues.
  - Branch operands are read in ID, so they are subject to the same hazard check.
- fwd_en change: takes effect for the next issued instruction. Existing counters keep counting down.
- stall_count:
  - Increments on each rising edge with rst=1 and hazard_detected=1.
  - Holds at all-ones (saturates).

Test Plan:
- Reset: drive rst=0 for 2 cycles with random ID inputs -> stall_count=0, all pend=0. Then rst=1 with id_src1=5, valid -> hazard_detected=0.
- No forwarding, back-to-back (fwd_en=0): issue ADD r3←r1,r2, then SUB r4←r3,r5 -> hazard_detected=1 for exactly 2 cycles, SUB issues on the 3rd cycle, stall_count=2.
- Forwarding load-use (fwd_en=1): LD r7, then ADD r8←r7,r1 -> 1 stall cycle. Repeat with ADD r7 as the producer -> 0 stall cycles.
- Immediate/r0 masking: producer writes r0, consumer reads r0 -> no stall. Consumer ADDI with id_src2 matching a pending register but id_use_src2=0 -> no stall. Same with id_use_src2=1 (ST/BNE) -> stall.
- Branch: taken BEZ on a pending r2 -> flush=0 while stalled, flush=1 in the single cycle it issues. Taken jump with no hazard -> flush=1 immediately.
- Reset mid-flight: issue LD r9 (fwd_en=0), pull rst low for one edge, then read r9 -> no stall. Separately force 2^16+5 stall cycles -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bundle.
// The master is the ID stage and the slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   fwd_en;
    logic                   id_valid;
    logic [4:0]             id_src1;
    logic [4:0]             id_src2;
    logic                   id_use_src2;
    logic [4:0]             id_dest;
    logic                   id_WB_en;
    logic                   id_MEM_R_en;
    logic                   id_Br_taken;
    logic                   hazard_detected;
    logic                   freeze;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output fwd_en, id_valid, id_src1, id_src2, id_use_src2,
        output id_dest, id_WB_en, id_MEM_R_en, id_Br_taken,
        input  hazard_detected, freeze, flush, stall_count
    );

    modport slave (
        input  fwd_en, id_valid, id_src1, id_src2, id_use_src2,
        input  id_dest, id_WB_en, id_MEM_R_en, id_Br_taken,
        output hazard_detected, freeze, flush, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW scoreboard: a per-register countdown of in-flight writes.
// It produces the stall, freeze and flush signals and a saturating stall counter.
module hazard_scoreboard #(
    parameter int WB_LATENCY  = 3,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    logic [CNT_W-1:0]       pend [32];
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   src1_busy;
    logic                   src2_busy;
    logic                   hazard;
    logic                   issue;
    logic                   do_load;
    logic [CNT_W-1:0]       load_val;

    // Entry 0 is held at zero, so r0 never reports busy.
    assign src1_busy = (sb.id_src1 != 5'd0) && (pend[sb.id_src1] != '0);
    assign src2_busy = sb.id_use_src2 && (sb.id_src2 != 5'd0)
                       && (pend[sb.id_src2] != '0);
    assign hazard    = sb.id_valid && (src1_busy || src2_busy);
    assign issue     = sb.id_valid && !hazard;

    // With forwarding, only a load leaves a result that cannot be bypassed.
    assign do_load  = issue && sb.id_WB_en && (sb.id_dest != 5'd0)
                      && (!sb.fwd_en || sb.id_MEM_R_en);
    assign load_val = sb.fwd_en ? CNT_W'(1) : CNT_W'(WB_LATENCY - 1);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (!rst || i == 0)
                pend[i] <= '0;
            else if (do_load && sb.id_dest == 5'(i))
                pend[i] <= load_val;
            else if (pend[i] != '0)
                pend[i] <= pend[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stall_q <= '0;
        else if (hazard && stall_q != '1)
            stall_q <= stall_q + STALL_CNT_W'(1);
    end

    assign sb.hazard_detected = hazard;
    assign sb.freeze          = hazard;
    assign sb.flush           = sb.id_Br_taken && issue;
    assign sb.stall_count     = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vectors for the hazard scoreboard.
// A narrow second instance covers counter saturation.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STALL_CNT_W(16)) bus ();
    hazard_scoreboard_if #(.STALL_CNT_W(4))  bus2 ();

    hazard_scoreboard #(.WB_LATENCY(3), .CNT_W(2), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sb(bus.slave)
    );
    hazard_scoreboard #(.WB_LATENCY(3), .CNT_W(2), .STALL_CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .sb(bus2.slave)
    );

    typedef struct {
        logic        rst;
        logic        fwd;
        logic        valid;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic        use2;
        logic [4:0]  dest;
        logic        wb;
        logic        mr;
        logic        br;
        logic        haz;
        logic        fl;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic r, logic f, logic v, int s1, int s2, logic u2, int d,
        logic wb, logic mr, logic br, logic haz, logic fl, int st
    );
        vec_t x;
        x.rst = r;
        x.fwd = f;
        x.valid = v;
        x.src1 = 5'(s1);
        x.src2 = 5'(s2);
        x.use2 = u2;
        x.dest = 5'(d);
        x.wb = wb;
        x.mr = mr;
        x.br = br;
        x.haz = haz;
        x.fl = fl;
        x.stall = 16'(st);
        return x;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0h want %0h", idx, nm, got, exp);
        end
    endtask

    initial begin
        // Columns: rst fwd valid src1 src2 use2 dest wb mr br | haz flush stall
        vecs.push_back(mk(1,0,1, 5, 0,0, 0,0,0,0, 0,0,0));
        // No forwarding: ADD r3, then SUB r4 <- r3
        vecs.push_back(mk(1,0,1, 1, 2,1, 3,1,0,0, 0,0,0));
        vecs.push_back(mk(1,0,1, 3, 5,1, 4,1,0,0, 1,0,0));
        vecs.push_back(mk(1,0,1, 3, 5,1, 4,1,0,0, 1,0,1));
        vecs.push_back(mk(1,0,1, 3, 5,1, 4,1,0,0, 0,0,2));
        vecs.push_back(mk(1,0,0, 0, 0,0, 0,0,0,0, 0,0,2));
        vecs.push_back(mk(1,0,0, 0, 0,0, 0,0,0,0, 0,0,2));
        // One independent instruction in between
        vecs.push_back(mk(1,0,1, 1, 2,1, 6,1,0,0, 0,0,2));
        vecs.push_back(mk(1,0,1, 1, 2,1,10,1,0,0, 0,0,2));
        vecs.push_back(mk(1,0,1, 6, 0,0,11,1,0,0, 1,0,2));
        vecs.push_back(mk(1,0,1, 6, 0,0,11,1,0,0, 0,0,3));
        // Two independent instructions in between
        vecs.push_back(mk(1,0,1, 1, 2,1,12,1,0,0, 0,0,3));
        vecs.push_back(mk(1,0,1, 1, 2,1,13,1,0,0, 0,0,3));
        vecs.push_back(mk(1,0,1, 1, 2,1,14,1,0,0, 0,0,3));
        vecs.push_back(mk(1,0,1,12, 0,0, 0,0,0,0, 0,0,3));
        // Forwarding: a load-use stalls once, an ALU producer never stalls
        vecs.push_back(mk(1,1,1, 1, 0,0, 7,1,1,0, 0,0,3));
        vecs.push_back(mk(1,1,1, 7, 1,1, 8,1,0,0, 1,0,3));
        vecs.push_back(mk(1,1,1, 7, 1,1, 8,1,0,0, 0,0,4));
        vecs.push_back(mk(1,1,1, 1, 2,1, 7,1,0,0, 0,0,4));
        vecs.push_back(mk(1,1,1, 7, 1,1, 8,1,0,0, 0,0,4));
        // r0 and immediate masking
        vecs.push_back(mk(1,0,1, 1, 0,0, 0,1,0,0, 0,0,4));
        vecs.push_back(mk(1,0,1, 0, 0,1, 9,1,0,0, 0,0,4));
        vecs.push_back(mk(1,0,1, 1, 2,1,15,1,0,0, 0,0,4));
        vecs.push_back(mk(1,0,1, 1,15,0,16,1,0,0, 0,0,4));
        vecs.push_back(mk(1,0,1, 1,15,1, 0,0,0,0, 1,0,4));
        vecs.push_back(mk(1,0,1, 1,15,1, 0,0,0,0, 0,0,5));
        // Taken branch on a pending register, then an unhazarded jump
        vecs.push_back(mk(1,0,1, 1, 0,0, 2,1,0,0, 0,0,5));
        vecs.push_back(mk(1,0,1, 2, 0,0, 0,0,0,1, 1,0,5));
        vecs.push_back(mk(1,0,1, 2, 0,0, 0,0,0,1, 1,0,6));
        vecs.push_back(mk(1,0,1, 2, 0,0, 0,0,0,1, 0,1,7));
        vecs.push_back(mk(1,0,1, 0, 0,0, 0,0,0,1, 0,1,7));
        vecs.push_back(mk(1,0,0, 0, 0,0, 0,0,0,1, 0,0,7));
        // Self-dependence checks the old count before reloading
        vecs.push_back(mk(1,0,1,20, 0,0,20,1,0,0, 0,0,7));
        vecs.push_back(mk(1,0,1,20, 0,0,20,1,0,0, 1,0,7));
        vecs.push_back(mk(1,0,1,20, 0,0,20,1,0,0, 1,0,8));
        vecs.push_back(mk(1,0,1,20, 0,0,20,1,0,0, 0,0,9));
        vecs.push_back(mk(1,0,0, 0, 0,0, 0,0,0,0, 0,0,9));
        // fwd_en rises while r20 is still counting down
        vecs.push_back(mk(1,1,1,20, 0,0, 0,0,0,0, 1,0,9));
        vecs.push_back(mk(1,1,1,20, 0,0, 0,0,0,0, 0,0,10));
        // A reset mid-flight discards the in-flight load to r9
        vecs.push_back(mk(1,0,1, 1, 0,0, 9,1,1,0, 0,0,10));
        vecs.push_back(mk(0,0,0, 0, 0,0, 0,0,0,0, 0,0,10));
        vecs.push_back(mk(1,0,1, 9, 9,1, 0,0,0,0, 0,0,0));

        rst = 1'b0;
        rst2 = 1'b0;
        bus2.fwd_en = 1'b0;
        bus2.id_valid = 1'b0;
        bus2.id_src1 = 5'd0;
        bus2.id_src2 = 5'd0;
        bus2.id_use_src2 = 1'b0;
        bus2.id_dest = 5'd0;
        bus2.id_WB_en = 1'b0;
        bus2.id_MEM_R_en = 1'b0;
        bus2.id_Br_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.fwd_en = 1'($urandom);
            bus.id_valid = 1'($urandom);
            bus.id_src1 = 5'($urandom);
            bus.id_src2 = 5'($urandom);
            bus.id_use_src2 = 1'($urandom);
            bus.id_dest = 5'($urandom);
            bus.id_WB_en = 1'($urandom);
            bus.id_MEM_R_en = 1'($urandom);
            bus.id_Br_taken = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("reset_stall", -1, 32'(bus.stall_count), 32'd0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus.fwd_en = vecs[i].fwd;
            bus.id_valid = vecs[i].valid;
            bus.id_src1 = vecs[i].src1;
            bus.id_src2 = vecs[i].src2;
            bus.id_use_src2 = vecs[i].use2;
            bus.id_dest = vecs[i].dest;
            bus.id_WB_en = vecs[i].wb;
            bus.id_MEM_R_en = vecs[i].mr;
            bus.id_Br_taken = vecs[i].br;
            #4;
            chk("hazard", i, 32'(bus.hazard_detected), 32'(vecs[i].haz));
            chk("freeze", i, 32'(bus.freeze), 32'(vecs[i].haz));
            chk("flush", i, 32'(bus.flush), 32'(vecs[i].fl));
            chk("stall_count", i, 32'(bus.stall_count), 32'(vecs[i].stall));
            @(posedge clk);
            #1;
        end

        // A self-dependent ADD r1 <- r1 stalls on two of every three cycles.
        rst2 = 1'b1;
        bus2.id_valid = 1'b1;
        bus2.id_src1 = 5'd1;
        bus2.id_dest = 5'd1;
        bus2.id_WB_en = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("sat_mid", 100, 32'(bus2.stall_count), 32'd6);
        repeat (40) @(posedge clk);
        #1;
        chk("sat_hold", 101, 32'(bus2.stall_count), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
